bsg_nonsynth_print_stat_tracker: RTL
====================================

# bsg_nonsynth_print_stat_tracker

Consumes the `print_stat_v`/`print_stat_tag` stream produced by `bsg_nonsynth_manycore_io_complex` in the SPMD testbench. Decodes each tag into start, end, or snapshot events, keeps a per-tag start timestamp against a free-running cycle counter, and emits completed measurement records through a small valid/yumi FIFO. Typical consumers are a profiler dump or a scoreboard. The input stream has no backpressure, so records are dropped and counted when the FIFO is full.

## Interface
- `data_width_p`, 32, width of `print_stat_tag_i`
- `tag_id_width_p`, 4, tag id field width; `num_tags_p = 2**tag_id_width_p`
- `ctr_width_p`, 32, cycle counter and record value width
- `fifo_els_p`, 4, output record FIFO depth (power of 2, ≥2)
- `err_width_p`, 16, width of the saturating error counters

Ports:
- `clk_i`  in  1  core clock
- `reset_i`  in  1  reset; asynchronous, active-high
- `print_stat_v_i`  in  1  tag valid; one event per cycle; no ready
- `print_stat_tag_i`  in  `data_width_p`  tag word; [31:30] kind (0 START, 1 END, 2 SNAP, 3 RSVD); [`tag_id_width_p`-1:0] tag id
- `v_o`  out  1  record valid
- `kind_o`  out  2  record kind (1 END, 2 SNAP)
- `tag_id_o`  out  `tag_id_width_p`  record tag id
- `value_o`  out  `ctr_width_p`  END: elapsed cycles; SNAP: absolute counter value
- `yumi_i`  in  1  consumer takes the head record; legal only when `v_o`=1
- `active_o`  out  `num_tags_p`  per-tag "started, not ended" bitmask
- `ctr_o`  out  `ctr_width_p`  current cycle counter
- `drop_count_o`, `orphan_count_o`, `overlap_count_o`, `rsvd_count_o`  out  `err_width_p`  saturating error counters

## Operation
- Counter: 0 in the first cycle after reset deasserts; increments by 1 every cycle; wraps modulo 2^`ctr_width_p`.
- START(id):
  - If `active[id]`=0, sets it and stores `start[id]=ctr`.
  - If `active[id]`=1, `overlap_count`++ and the timestamp is overwritten with the current `ctr`.
  - No record is produced.
- END(id):
  - If `active[id]`=1, pushes {END, id, `ctr - start[id]` mod 2^`ctr_width_p`} and clears `active[id]`.
  - If `active[id]`=0, `orphan_count`++ and nothing is pushed.
- SNAP(id): pushes {SNAP, id, `ctr`}. Tag state is unchanged.
- RSVD: `rsvd_count`++; otherwise ignored.
- Bits of the tag word between the kind field and the id field are ignored.
- Push when the FIFO is full:
  - If `yumi_i`=1 in the same cycle, the push is accepted.
  - Otherwise the record is discarded, `drop_count`++, and tag state updates still apply (END still clears `active`).
- Error counters saturate at all-ones.
- FIFO: in-order; head is presented on `v_o`/`kind_o`/`tag_id_o`/`value_o`. `yumi_i` with `v_o`=0 is a protocol error (covered by an assertion, no effect).

## Timing
- Event sampled at rising edge t; its record is visible at the outputs after edge t (registered, 1-cycle latency) when the FIFO was empty.
- `active_o` and the error counters update at the same edge the event is sampled.
- Record value uses the `ctr` value held during the sampling cycle.
- Simultaneous push and pop:
  - Empty FIFO: the new record appears next cycle.
  - Full FIFO: count is unchanged and no drop occurs.
- Reset (asynchronous, any time):
  - Clears counter, `active`, FIFO (`v_o`=0), and all error counters.
  - Reset values: `v_o`=0, `kind_o`=0, `tag_id_o`=0, `value_o`=0, `active_o`=0, `ctr_o`=0, all counts 0.
  - Events in the reset cycle are ignored.

## Configuration
- `BSG_PRINT_STAT_TRACKER_DISPLAY_EN` defined:
  - Every accepted record is `$display`ed at push time as "[PRINT_STAT] kind=%s id=%0d value=%0d ctr=%0d".
  - Drop, orphan, overlap, and reserved events are printed as warnings.
- Not defined: no simulation output; datapath behaviour is identical.

## Test plan
- START id 3 at ctr 10, END id 3 at ctr 110, `yumi_i` held 1 → one record {END, 3, 100} at ctr 111; `active_o[3]` is 1 during ctr 11–110 and 0 from ctr 111.
- Preload counter near wrap (`ctr_width_p`=8): START id 1 at ctr 250, END at ctr 4 → value 10.
- END id 5 with no START → no record; `orphan_count_o`=1. Two STARTs on id 2 at ctr 20 and 30, END at 50 → `overlap_count_o`=1, value 20.
- `yumi_i`=0, 6 SNAPs on consecutive cycles with `fifo_els_p`=4 → 4 records held, `drop_count_o`=2. Then SNAP with `yumi_i`=1 while full → no extra drop; records drain in order.
- Assert reset mid-interval (START id 7 pending, FIFO holding 2) → all outputs 0 immediately; after release the counter restarts at 0 and END id 7 counts as an orphan.
- Kind 3 tag → `rsvd_count_o`=1, no record, `active_o` unchanged.

Source files
------------

// File: rtl/bsg_nonsynth_print_stat_tracker.sv
// rtl/bsg_nonsynth_print_stat_tracker.sv - print_stat start/end/snapshot tracker with record FIFO and error counters
// Define BSG_PRINT_STAT_TRACKER_DISPLAY_EN to print accepted records and warnings.
module bsg_nonsynth_print_stat_tracker #(
    parameter int data_width_p   = 32,
    parameter int tag_id_width_p = 4,
    parameter int ctr_width_p    = 32,
    parameter int fifo_els_p     = 4,
    parameter int err_width_p    = 16
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             print_stat_v_i,
    input  logic [data_width_p-1:0]          print_stat_tag_i,
    output logic                             v_o,
    output logic [1:0]                       kind_o,
    output logic [tag_id_width_p-1:0]        tag_id_o,
    output logic [ctr_width_p-1:0]           value_o,
    input  logic                             yumi_i,
    output logic [(1<<tag_id_width_p)-1:0]   active_o,
    output logic [ctr_width_p-1:0]           ctr_o,
    output logic [err_width_p-1:0]           drop_count_o,
    output logic [err_width_p-1:0]           orphan_count_o,
    output logic [err_width_p-1:0]           overlap_count_o,
    output logic [err_width_p-1:0]           rsvd_count_o
);

    localparam int num_tags_p = 1 << tag_id_width_p;
    localparam int ptr_w      = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam logic [ptr_w:0] full_count = fifo_els_p[ptr_w:0];

    localparam logic [1:0] kind_start = 2'd0;
    localparam logic [1:0] kind_end   = 2'd1;
    localparam logic [1:0] kind_snap  = 2'd2;
    localparam logic [1:0] kind_rsvd  = 2'd3;

    logic [ctr_width_p-1:0]    ctr_r;
    logic [num_tags_p-1:0]     active_r;
    logic [num_tags_p-1:0]     active_n;
    logic [ctr_width_p-1:0]    start_r [num_tags_p];

    logic [1:0]                mem_kind  [fifo_els_p];
    logic [tag_id_width_p-1:0] mem_id    [fifo_els_p];
    logic [ctr_width_p-1:0]    mem_value [fifo_els_p];
    logic [ptr_w-1:0]          wr_ptr;
    logic [ptr_w-1:0]          rd_ptr;
    logic [ptr_w:0]            count;

    logic [err_width_p-1:0]    drop_cnt;
    logic [err_width_p-1:0]    orphan_cnt;
    logic [err_width_p-1:0]    overlap_cnt;
    logic [err_width_p-1:0]    rsvd_cnt;

    logic [1:0]                ev_kind;
    logic [tag_id_width_p-1:0] ev_id;
    logic                      ev_v;
    logic                      start_ev;
    logic                      end_ev;
    logic                      snap_ev;
    logic                      rsvd_ev;
    logic                      overlap;
    logic                      orphan;
    logic                      push_req;
    logic                      push;
    logic                      pop;
    logic                      drop;
    logic                      empty;
    logic                      full;
    logic [1:0]                rec_kind;
    logic [ctr_width_p-1:0]    rec_value;
    logic                      unused_tag_bits;

    // Only the kind field and the id field carry meaning; the bits between them are ignored.
    assign ev_kind         = print_stat_tag_i[data_width_p-1 -: 2];
    assign ev_id           = print_stat_tag_i[tag_id_width_p-1:0];
    assign unused_tag_bits = ^print_stat_tag_i[data_width_p-3:tag_id_width_p];

    assign ev_v     = print_stat_v_i & ~reset_i;
    assign start_ev = ev_v & (ev_kind == kind_start);
    assign end_ev   = ev_v & (ev_kind == kind_end);
    assign snap_ev  = ev_v & (ev_kind == kind_snap);
    assign rsvd_ev  = ev_v & (ev_kind == kind_rsvd);

    assign overlap  = start_ev & active_r[ev_id];
    assign orphan   = end_ev & ~active_r[ev_id];

    assign empty    = (count == '0);
    assign full     = (count == full_count);
    assign pop      = yumi_i & ~empty;
    assign push_req = snap_ev | (end_ev & active_r[ev_id]);
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_comb begin
        rec_kind  = kind_snap;
        rec_value = ctr_r;
        if (end_ev) begin
            rec_kind  = kind_end;
            rec_value = ctr_r - start_r[ev_id];
        end
    end

    always_comb begin
        active_n = active_r;
        if (start_ev) begin
            active_n[ev_id] = 1'b1;
        end
        if (end_ev) begin
            active_n[ev_id] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ctr_r       <= '0;
            active_r    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            drop_cnt    <= '0;
            orphan_cnt  <= '0;
            overlap_cnt <= '0;
            rsvd_cnt    <= '0;
        end else begin
            ctr_r    <= ctr_r + 1'b1;
            active_r <= active_n;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (drop && ~&drop_cnt) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            if (orphan && ~&orphan_cnt) begin
                orphan_cnt <= orphan_cnt + 1'b1;
            end
            if (overlap && ~&overlap_cnt) begin
                overlap_cnt <= overlap_cnt + 1'b1;
            end
            if (rsvd_ev && ~&rsvd_cnt) begin
                rsvd_cnt <= rsvd_cnt + 1'b1;
            end
        end
    end

    // Storage needs no reset: the pointers and the active mask qualify every read.
    always_ff @(posedge clk_i) begin
        if (start_ev) begin
            start_r[ev_id] <= ctr_r;
        end
        if (push) begin
            mem_kind[wr_ptr]  <= rec_kind;
            mem_id[wr_ptr]    <= ev_id;
            mem_value[wr_ptr] <= rec_value;
        end
    end

    assign v_o             = ~empty;
    assign kind_o          = empty ? 2'd0 : mem_kind[rd_ptr];
    assign tag_id_o        = empty ? '0 : mem_id[rd_ptr];
    assign value_o         = empty ? '0 : mem_value[rd_ptr];
    assign active_o        = active_r;
    assign ctr_o           = ctr_r;
    assign drop_count_o    = drop_cnt;
    assign orphan_count_o  = orphan_cnt;
    assign overlap_count_o = overlap_cnt;
    assign rsvd_count_o    = rsvd_cnt;

    yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o)
        else $error("yumi_i asserted while v_o is low");

`ifdef BSG_PRINT_STAT_TRACKER_DISPLAY_EN
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (push) begin
                $display("[PRINT_STAT] kind=%s id=%0d value=%0d ctr=%0d",
                         (rec_kind == kind_end) ? "END" : "SNAP", ev_id, rec_value, ctr_r);
            end
            if (drop) begin
                $display("[PRINT_STAT] warning: record dropped id=%0d ctr=%0d", ev_id, ctr_r);
            end
            if (orphan) begin
                $display("[PRINT_STAT] warning: END without START id=%0d ctr=%0d", ev_id, ctr_r);
            end
            if (overlap) begin
                $display("[PRINT_STAT] warning: START while active id=%0d ctr=%0d", ev_id, ctr_r);
            end
            if (rsvd_ev) begin
                $display("[PRINT_STAT] warning: reserved tag kind id=%0d ctr=%0d", ev_id, ctr_r);
            end
        end
    end
`endif

endmodule
